mmio_responder: RTL and testbench

Memory-mapped I/O responder sitting on the data side of the single-cycle CPU, opposite the execute stage: it consumes the execute stage's computed address together with the controller's read/write strobes. For addresses inside the I/O window it completes the access through a wait-state handshake and returns read data, while the CPU stalls. It owns the LED output register, a synchronized switch input port and an optional free-running timer.

---
 rtl/mmio_pkg.sv | 21 ++
 rtl/mmio_sync2.sv | 33 +++
 rtl/mmio_responder.sv | 159 +++++++++++++++
 tb/tb_mmio_responder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// ============================================================================
// mmio_pkg : shared constants for the memory-mapped I/O responder
// Rev 1.0
// ============================================================================
`default_nettype none

package mmio_pkg;

  localparam int WIN_W = 10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  localparam logic [WIN_W-1:0] LED_OFF   = 10'h060;
  localparam logic [WIN_W-1:0] SW_OFF    = 10'h070;
  localparam logic [WIN_W-1:0] TIMER_OFF = 10'h080;

endpackage

`default_nettype wire

// File: rtl/mmio_sync2.sv
// ============================================================================
// mmio_sync2 : parameterized-width two-flop synchronizer, synchronous reset
// Rev 1.0
// ============================================================================
`default_nettype none

module mmio_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/mmio_responder.sv
// ============================================================================
// mmio_responder : wait-state MMIO responder (LED, switches, optional timer)
// Optional free-running timer at offset 0x080 enabled by `define MMIO_TIMER_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module mmio_responder
  import mmio_pkg::*;
#(
  parameter logic [31:0] IO_BASE     = 32'hFFFF_FC00,
  parameter int          WAIT_STATES = 2,
  parameter int          IO_WIDTH    = 24
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [31:0]         Addr_in,
  input  logic                MemRead,
  input  logic                MemWrite,
  input  logic [31:0]         Wdata,
  output logic                io_hit,
  output logic                io_ready,
  output logic [31:0]         Rdata,
  input  logic [IO_WIDTH-1:0] switch_in,
  output logic [IO_WIDTH-1:0] led_out
);

  logic [1:0]          state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [WIN_W-1:0]    off_q, off_d;
  logic                rw_q, rw_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [IO_WIDTH-1:0] led_q, led_d;
  logic [IO_WIDTH-1:0] sw_sync;
  logic                req;
  logic                load_rd;
  logic                commit;
  logic [WIN_W-1:0]    live_off;
  logic [WIN_W-1:0]    rd_off;
  logic [31:0]         rd_val;
  logic                unused_bits;

  mmio_sync2 #(
    .WIDTH (IO_WIDTH)
  ) u_sw_sync (
    .clock (clock),
    .reset (reset),
    .d_i   (switch_in),
    .q_o   (sw_sync)
  );

  assign io_hit   = (Addr_in[31:WIN_W] == IO_BASE[31:WIN_W]);
  assign req      = io_hit & (MemRead | MemWrite);
  assign live_off = {Addr_in[WIN_W-1:2], 2'b00};
  assign io_ready = (state_q == ST_ACK);
  assign Rdata    = rdata_q;
  assign led_out  = led_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    load_rd = 1'b0;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          off_d   = live_off;
          rw_d    = MemWrite;
          wdata_d = Wdata;
          if (WAIT_STATES == 0) begin
            state_d = ST_ACK;
            load_rd = ~MemWrite;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_STATES);
          end
        end
      end
      ST_WAIT: begin
        // A dropped request aborts before any side effect can occur.
        if (!req) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_ACK;
          load_rd = ~rw_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
        commit  = rw_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A zero-wait read loads from IDLE before the offset register is written.
  assign rd_off = (state_q == ST_IDLE) ? live_off : off_q;

`ifdef MMIO_TIMER_EN
  logic [31:0] timer_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      timer_q <= '0;
    end else if (commit && (off_q == TIMER_OFF)) begin
      timer_q <= wdata_q;
    end else begin
      timer_q <= timer_q + 32'd1;
    end
  end
`endif

  always_comb begin
    rd_val = '0;
    case (rd_off)
      LED_OFF:   rd_val[IO_WIDTH-1:0] = led_q;
      SW_OFF:    rd_val[IO_WIDTH-1:0] = sw_sync;
`ifdef MMIO_TIMER_EN
      TIMER_OFF: rd_val = timer_q;
`endif
      default:   rd_val = '0;
    endcase
  end

  assign rdata_d = load_rd ? rd_val : rdata_q;
  assign led_d   = (commit && (off_q == LED_OFF)) ? wdata_q[IO_WIDTH-1:0] : led_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      off_q   <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      led_q   <= led_d;
    end
  end

  assign unused_bits = ^{Addr_in[1:0], wdata_q};

endmodule

`default_nettype wire

// File: tb/tb_mmio_responder.sv
// ============================================================================
// tb_mmio_responder : directed self-checking bench for mmio_responder
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mmio_responder;
  import mmio_pkg::*;

  localparam int          WS   = 2;
  localparam int          IOW  = 24;
  localparam logic [31:0] BASE = 32'hFFFF_FC00;

  logic            clock = 1'b0;
  logic            reset;
  logic [31:0]     Addr_in;
  logic            MemRead;
  logic            MemWrite;
  logic [31:0]     Wdata;
  logic            io_hit;
  logic            io_ready;
  logic [31:0]     Rdata;
  logic [IOW-1:0]  switch_in;
  logic [IOW-1:0]  led_out;

  int              checks   = 0;
  int              failures = 0;
  logic [31:0]     r_ack, r_after, led_ack, exp_t;
  logic            seen;

  mmio_responder #(
    .IO_BASE     (BASE),
    .WAIT_STATES (WS),
    .IO_WIDTH    (IOW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .Addr_in   (Addr_in),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Wdata     (Wdata),
    .io_hit    (io_hit),
    .io_ready  (io_ready),
    .Rdata     (Rdata),
    .switch_in (switch_in),
    .led_out   (led_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_bus();
    Addr_in  = 32'h0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Wdata    = 32'h0;
  endtask

  // Holds the request until acknowledge, then one more cycle; optionally
  // disturbs address/data after capture to prove captured values are used.
  task automatic io_xfer(input string tag, input logic [31:0] addr, input logic rd,
                         input logic wr, input logic [31:0] wd, input bit mutate);
    int lat;
    lat      = 0;
    Addr_in  = addr;
    MemRead  = rd;
    MemWrite = wr;
    Wdata    = wd;
    do begin
      tick();
      lat++;
      if (mutate && lat == 1) begin
        Addr_in = BASE | 32'h070;
        Wdata   = ~wd;
      end
    end while (!io_ready && lat < 20);
    check({tag, "_lat"}, 32'(lat), 32'(WS + 2));
    r_ack   = Rdata;
    led_ack = 32'(led_out);
    tick();
    check({tag, "_onecyc"}, 32'(io_ready), 32'h0);
    r_after = Rdata;
    idle_bus();
  endtask

  initial begin
    reset     = 1'b1;
    switch_in = '0;
    idle_bus();
    repeat (3) tick();
    check("rst_ready", 32'(io_ready), 32'h0);
    check("rst_rdata", Rdata, 32'h0);
    check("rst_led",   32'(led_out), 32'h0);
    check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    reset = 1'b0;
    tick();

    // Reset in the middle of a write's wait phase
    Addr_in  = BASE | 32'h060;
    MemWrite = 1'b1;
    Wdata    = 32'h0000_00FF;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle_bus();
    check("midrst_state", 32'(dut.state_q), 32'(ST_IDLE));
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen |= io_ready;
    end
    check("midrst_ready", 32'(seen), 32'h0);
    check("midrst_led",   32'(led_out), 32'h0);
    check("midrst_rdata", Rdata, 32'h0);

    // LED write with latency and one-cycle acknowledge
    io_xfer("ledwr", BASE | 32'h060, 1'b0, 1'b1, 32'h00A5_A5A5, 1'b0);
    check("ledwr_led_at_ack", led_ack, 32'h0);
    check("ledwr_led", 32'(led_out), 32'h00A5_A5A5);

    // Bits above IO_WIDTH dropped on write, read back as 0
    io_xfer("ledfull", BASE | 32'h060, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    check("ledfull_led", 32'(led_out), 32'h00FF_FFFF);
    io_xfer("ledrd", BASE | 32'h060, 1'b1, 1'b0, 32'h0, 1'b0);
    check("ledrd_rdata", r_ack, 32'h00FF_FFFF);

    // Synchronized switch read, Rdata holds after
    switch_in = 24'h123456;
    repeat (3) tick();
    io_xfer("swrd", BASE | 32'h070, 1'b1, 1'b0, 32'h0, 1'b0);
    check("swrd_rdata", r_ack, 32'h0012_3456);
    check("swrd_hold1", r_after, 32'h0012_3456);
    switch_in = 24'h0;
    repeat (4) tick();
    check("swrd_hold2", Rdata, 32'h0012_3456);

    // Both strobes count as a write; Rdata untouched
    io_xfer("both", BASE | 32'h060, 1'b1, 1'b1, 32'h0000_005A, 1'b0);
    check("both_led",   32'(led_out), 32'h0000_005A);
    check("both_rdata", r_ack, 32'h0012_3456);

    // Switch port is read-only
    io_xfer("swwr", BASE | 32'h070, 1'b0, 1'b1, 32'h00AB_CDEF, 1'b0);
    check("swwr_led", 32'(led_out), 32'h0000_005A);

    // Address/data changes after capture are ignored
    io_xfer("capt", BASE | 32'h060, 1'b0, 1'b1, 32'h0011_1111, 1'b1);
    check("capt_led", 32'(led_out), 32'h0011_1111);

    // Abort one cycle after capture
    Addr_in  = BASE | 32'h060;
    MemWrite = 1'b1;
    Wdata    = 32'h0000_0000;
    tick();
    idle_bus();
    tick();
    check("abort_state", 32'(dut.state_q), 32'(ST_IDLE));
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen |= io_ready;
    end
    check("abort_ready", 32'(seen), 32'h0);
    check("abort_led",   32'(led_out), 32'h0011_1111);

    // Outside the window
    Addr_in  = 32'h0000_0010;
    MemWrite = 1'b1;
    Wdata    = 32'h0000_0000;
    #1;
    check("miss_hit", 32'(io_hit), 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen |= io_ready;
    end
    check("miss_ready", 32'(seen), 32'h0);
    check("miss_state", 32'(dut.state_q), 32'(ST_IDLE));
    check("miss_led",   32'(led_out), 32'h0011_1111);
    Addr_in = 32'hFFFF_FBFC;
    #1;
    check("below_hit", 32'(io_hit), 32'h0);
    Addr_in = 32'hFFFF_FFFC;
    #1;
    check("top_hit", 32'(io_hit), 32'h1);
    idle_bus();
    tick();

    // Refresh Rdata to a nonzero value, then read an unmapped offset
    switch_in = 24'h00BEEF;
    repeat (3) tick();
    io_xfer("swrd2", BASE | 32'h070, 1'b1, 1'b0, 32'h0, 1'b0);
    check("swrd2_rdata", r_ack, 32'h0000_BEEF);
    io_xfer("unmap", BASE, 1'b1, 1'b0, 32'h0, 1'b0);
    check("unmap_rdata", r_ack, 32'h0);

    // Timer: load near wrap, read three cycles after commit
`ifdef MMIO_TIMER_EN
    exp_t = 32'hFFFF_FFFE + 32'd3;
`else
    exp_t = 32'h0;
`endif
    io_xfer("tmrwr", BASE | 32'h080, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
    io_xfer("tmrrd", BASE | 32'h080, 1'b1, 1'b0, 32'h0, 1'b0);
    check("tmrrd_rdata", r_ack, exp_t);
    check("tmr_led", 32'(led_out), 32'h0011_1111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
